hilbert_delay_bank: RTL and testbench
=====================================

# hilbert_delay_bank

Multi-channel, parametrised successor to the single-ratio fake Hilbert stage. It sits between the antenna sample capture and the correlator front-end. For each of `WIDTH` 1-bit channels it decimates a supersampled stream by `RATIO` and emits a complex pair: the real part is the newest sample, and the imaginary part is the sample `SHIFT` input strobes earlier (a quarter-wave delay approximation). It also produces lock and frame-marker outputs for downstream block alignment.

## Interface
Parameters:
- `WIDTH`, 24, number of independent 1-bit channels.
- `RATIO`, 4, input samples per output sample; range 2..16.
- `SHIFT`, 1, delay in input samples between `re` and `im`; range 1..RATIO-1.
- `FRAME`, 8, outputs per frame-marker period; range 1..256.

Ports:
- `clk`  in  1  system clock.
- `rst`  in  1  reset, synchronous, active-low.
- `enable_i`  in  1  run enable; low clears sequencing state.
- `strobe_i`  in  1  input sample valid, one cycle per sample.
- `signal_i`  in  WIDTH  one input bit per channel.
- `locked_o`  out  1  level; high once the first output is produced since enable.
- `strobe_o`  out  1  one-cycle pulse per output sample.
- `framed_o`  out  1  pulse coincident with `strobe_o` on output index ≡ 0 mod FRAME.
- `sig_re_o`  out  WIDTH  real output.
- `sig_im_o`  out  WIDTH  imaginary output.

## Operation
- Per-channel history shift register, SHIFT+1 deep. It shifts in `signal_i` on each accepted strobe, where accepted means `strobe_i && enable_i`.
- Phase counter, ceil(log2 RATIO) bits, counts accepted strobes modulo RATIO, starting at 0.
- Accepted strobe with phase == RATIO-1 (last sample of a decimation window) produces an output:
  - `sig_re_o` ← the current `signal_i`.
  - `sig_im_o` ← the history entry SHIFT strobes back. It is always valid, because SHIFT < RATIO.
  - `strobe_o` ← 1.
  - `locked_o` ← 1.
  - `framed_o` ← 1 if the output counter == 0.
  - Output counter increments modulo FRAME.
- `enable_i` low:
  - Phase counter, output counter and history are cleared.
  - `locked_o` goes to 0, and `strobe_o` / `framed_o` go to 0.
  - `sig_re_o` / `sig_im_o` hold their last values.
  - Strobes are ignored.
- Re-enable restarts a fresh window. The first output needs RATIO new strobes, and it carries `framed_o` = 1.
- Back-to-back `strobe_i` (every cycle) is supported at full rate.
- Reset values: all outputs 0, phase 0, output counter 0, history 0.

## Timing
- Outputs are registered. `strobe_o`, `framed_o`, `sig_re_o` and `sig_im_o` update on the same edge that accepts the window's final strobe, and are visible for the following cycle.
- `strobe_o` and `framed_o` are high for exactly one cycle.
- `locked_o` rises with the first `strobe_o` and falls one edge after `enable_i` is sampled low.
- `rst` low takes priority over `enable_i` and `strobe_i`, on any cycle including mid-window. The next output needs RATIO accepted strobes after `rst` returns high.
- Simultaneous `enable_i` falling and a final-phase `strobe_i`: the strobe is not accepted and no output is produced.
- Phase counter and output counter wrap silently. There are no overflow flags.

## Configuration
- `HILBERT_NEGATE_IM_EN` defined: `sig_im_o` is the bitwise inverse of the delayed sample. This is a sign flip that selects the opposite sideband for 1-bit data.
- Undefined: `sig_im_o` is the delayed sample unmodified.
- No other behaviour changes with the macro.

## Test plan
Bench parameters: WIDTH=4, RATIO=4, SHIFT=1, FRAME=2. Strobes every other cycle unless stated.

1. Reset: hold `rst`=0 for 3 cycles with `enable_i`=1 and random strobes → all outputs are 0 throughout.
2. Enable, then signals 4'h1, 4'h2, 4'h3, 4'h4 → after the 4th strobe, one `strobe_o` pulse with re=4'h4, im=4'h3, `framed_o`=1 and `locked_o` rising. No output before that.
3. Continue with 5..8, then 9..C → second output re=4'h8, im=4'h7, `framed_o`=0; third output re=4'hC, im=4'hB, `framed_o`=1.
4. Drop `enable_i` after 2 strobes of a window, re-enable, feed 4'hA, 4'hB, 4'hC, 4'hD → `locked_o` is 0 while disabled, and re/im hold their previous values. Then a single output with re=4'hD, im=4'hC, `framed_o`=1.
5. `strobe_i` high every cycle for 16 cycles → exactly 4 `strobe_o` pulses, spaced 4 cycles apart.
6. With `HILBERT_NEGATE_IM_EN` defined, repeat scenario 2 → re=4'h4, im=4'hC.

Source files
------------

// File: rtl/hilbert_delay_bank.sv
// Multi-channel decimating fake-Hilbert stage: re = newest sample, im = sample SHIFT strobes back.
// Define HILBERT_NEGATE_IM_EN to emit the bitwise inverse of the delayed sample on sig_im_o.
module hilbert_delay_bank #(
  parameter int WIDTH = 24,
  parameter int RATIO = 4,
  parameter int SHIFT = 1,
  parameter int FRAME = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             enable_i,
  input  logic             strobe_i,
  input  logic [WIDTH-1:0] signal_i,
  output logic             locked_o,
  output logic             strobe_o,
  output logic             framed_o,
  output logic [WIDTH-1:0] sig_re_o,
  output logic [WIDTH-1:0] sig_im_o
);

  localparam int PW = (RATIO > 1) ? $clog2(RATIO) : 1;
  localparam int FW = (FRAME > 1) ? $clog2(FRAME) : 1;
  localparam logic [PW-1:0] PHASE_LAST = PW'(RATIO - 1);
  localparam logic [FW-1:0] FRAME_LAST = FW'(FRAME - 1);

  logic [PW-1:0]    r_phase;
  logic [FW-1:0]    r_frame;
  logic [WIDTH-1:0] r_hist [SHIFT];
  logic             r_locked;
  logic             r_strobe;
  logic             r_framed;
  logic [WIDTH-1:0] r_re;
  logic [WIDTH-1:0] r_im;

  logic             w_accept;
  logic             w_last;
  logic             w_emit;
  logic [PW-1:0]    w_phase_nxt;
  logic [FW-1:0]    w_frame_nxt;
  logic [WIDTH-1:0] w_delayed;
  logic [WIDTH-1:0] w_im;

  assign w_accept  = strobe_i & enable_i;
  assign w_last    = (r_phase == PHASE_LAST);
  assign w_emit    = w_accept & w_last;
  // r_hist[k] is the sample k+1 accepted strobes before the current one
  assign w_delayed = r_hist[SHIFT-1];

`ifdef HILBERT_NEGATE_IM_EN
  assign w_im = ~w_delayed;
`else
  assign w_im = w_delayed;
`endif

  // Next phase / output-counter values; both wrap silently.
  always_comb begin
    w_phase_nxt = r_phase;
    w_frame_nxt = r_frame;
    if (w_accept) begin
      if (w_last) begin
        w_phase_nxt = {PW{1'b0}};
        if (r_frame == FRAME_LAST) begin
          w_frame_nxt = {FW{1'b0}};
        end else begin
          w_frame_nxt = r_frame + FW'(1'b1);
        end
      end else begin
        w_phase_nxt = r_phase + PW'(1'b1);
        w_frame_nxt = r_frame;
      end
    end else begin
      w_phase_nxt = r_phase;
      w_frame_nxt = r_frame;
    end
  end

  // Sequencing counters, cleared by reset or by dropping enable.
  always_ff @(posedge clk) begin
    if (!rst || !enable_i) begin
      r_phase <= {PW{1'b0}};
      r_frame <= {FW{1'b0}};
    end else begin
      r_phase <= w_phase_nxt;
      r_frame <= w_frame_nxt;
    end
  end

  // Per-channel sample history, advanced on every accepted strobe.
  always_ff @(posedge clk) begin
    if (!rst || !enable_i) begin
      for (int k = 0; k < SHIFT; k++) begin
        r_hist[k] <= {WIDTH{1'b0}};
      end
    end else if (w_accept) begin
      r_hist[0] <= signal_i;
      for (int k = 1; k < SHIFT; k++) begin
        r_hist[k] <= r_hist[k-1];
      end
    end else begin
      for (int k = 0; k < SHIFT; k++) begin
        r_hist[k] <= r_hist[k];
      end
    end
  end

  // Registered outputs; data holds across disable, pulses and lock drop.
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_locked <= 1'b0;
      r_strobe <= 1'b0;
      r_framed <= 1'b0;
      r_re     <= {WIDTH{1'b0}};
      r_im     <= {WIDTH{1'b0}};
    end else if (!enable_i) begin
      r_locked <= 1'b0;
      r_strobe <= 1'b0;
      r_framed <= 1'b0;
      r_re     <= r_re;
      r_im     <= r_im;
    end else begin
      r_strobe <= w_emit;
      r_framed <= w_emit & (r_frame == {FW{1'b0}});
      if (w_emit) begin
        r_locked <= 1'b1;
        r_re     <= signal_i;
        r_im     <= w_im;
      end else begin
        r_locked <= r_locked;
        r_re     <= r_re;
        r_im     <= r_im;
      end
    end
  end

  assign locked_o = r_locked;
  assign strobe_o = r_strobe;
  assign framed_o = r_framed;
  assign sig_re_o = r_re;
  assign sig_im_o = r_im;

endmodule

// File: tb/tb_hilbert_delay_bank.sv
// Self-checking bench for hilbert_delay_bank: directed vector table, corner sequences,
// and randomized stimulus against a queue-based reference model.
module tb_hilbert_delay_bank;

  localparam int WIDTH = 4;
  localparam int RATIO = 4;
  localparam int SHIFT = 1;
  localparam int FRAME = 2;

  logic             clk;
  logic             rst;
  logic             enable_i;
  logic             strobe_i;
  logic [WIDTH-1:0] signal_i;
  logic             locked_o;
  logic             strobe_o;
  logic             framed_o;
  logic [WIDTH-1:0] sig_re_o;
  logic [WIDTH-1:0] sig_im_o;

  hilbert_delay_bank #(
    .WIDTH(WIDTH), .RATIO(RATIO), .SHIFT(SHIFT), .FRAME(FRAME)
  ) dut (
    .clk(clk), .rst(rst), .enable_i(enable_i), .strobe_i(strobe_i),
    .signal_i(signal_i), .locked_o(locked_o), .strobe_o(strobe_o),
    .framed_o(framed_o), .sig_re_o(sig_re_o), .sig_im_o(sig_im_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_chk = 0;
  int n_err = 0;

  typedef struct {
    logic       en;
    logic       stb;
    logic [3:0] sig;
    logic       e_stb;
    logic       e_frm;
    logic       e_lock;
    logic [3:0] e_re;
    logic [3:0] e_im;
  } vec_t;

  vec_t tbl[$];

  // reference model state
  logic [3:0] q[$];
  int         m_acc;
  int         m_out;
  logic       m_lock, m_stb, m_frm;
  logic [3:0] m_re, m_im;

  function automatic logic [3:0] imx(input logic [3:0] v);
`ifdef HILBERT_NEGATE_IM_EN
    return ~v;
`else
    return v;
`endif
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic model(input logic r, input logic e, input logic s, input logic [3:0] d);
    if (!r) begin
      q.delete(); m_acc = 0; m_out = 0;
      m_lock = 1'b0; m_stb = 1'b0; m_frm = 1'b0; m_re = 4'h0; m_im = 4'h0;
    end else if (!e) begin
      q.delete(); m_acc = 0; m_out = 0;
      m_lock = 1'b0; m_stb = 1'b0; m_frm = 1'b0;
    end else begin
      m_stb = 1'b0; m_frm = 1'b0;
      if (s) begin
        q.push_back(d);
        m_acc++;
        if (m_acc % RATIO == 0) begin
          m_re   = d;
          m_im   = imx(q[q.size()-1-SHIFT]);
          m_stb  = 1'b1;
          m_lock = 1'b1;
          m_frm  = (m_out % FRAME == 0);
          m_out++;
        end
        if (q.size() > 16) void'(q.pop_front());
      end
    end
  endtask

  task automatic step(input logic r, input logic e, input logic s, input logic [3:0] d);
    rst = r; enable_i = e; strobe_i = s; signal_i = d;
    @(posedge clk);
    model(r, e, s, d);
    #1;
  endtask

  task automatic add(input logic en, input logic stb, input logic [3:0] sig, input logic e_stb,
                     input logic e_frm, input logic e_lock, input logic [3:0] e_re, input logic [3:0] e_im);
    vec_t v;
    v.en = en; v.stb = stb; v.sig = sig; v.e_stb = e_stb; v.e_frm = e_frm;
    v.e_lock = e_lock; v.e_re = e_re; v.e_im = e_im;
    tbl.push_back(v);
  endtask

  // one strobed sample followed by an idle cycle
  task automatic samp(input logic [3:0] sig, input logic e_stb, input logic e_frm,
                      input logic e_lock, input logic [3:0] e_re, input logic [3:0] e_im);
    add(1'b1, 1'b1, sig, e_stb, e_frm, e_lock, e_re, e_im);
    add(1'b1, 1'b0, sig, 1'b0, 1'b0, e_lock, e_re, e_im);
  endtask

  initial begin
    int pulses[$];
    logic frms[$];
    logic r, e, s;
    logic [3:0] d;

    // first output of a fresh window, then two more
    samp(4'h1, 1'b0, 1'b0, 1'b0, 4'h0, 4'h0);
    samp(4'h2, 1'b0, 1'b0, 1'b0, 4'h0, 4'h0);
    samp(4'h3, 1'b0, 1'b0, 1'b0, 4'h0, 4'h0);
    samp(4'h4, 1'b1, 1'b1, 1'b1, 4'h4, imx(4'h3));
    samp(4'h5, 1'b0, 1'b0, 1'b1, 4'h4, imx(4'h3));
    samp(4'h6, 1'b0, 1'b0, 1'b1, 4'h4, imx(4'h3));
    samp(4'h7, 1'b0, 1'b0, 1'b1, 4'h4, imx(4'h3));
    samp(4'h8, 1'b1, 1'b0, 1'b1, 4'h8, imx(4'h7));
    samp(4'h9, 1'b0, 1'b0, 1'b1, 4'h8, imx(4'h7));
    samp(4'hA, 1'b0, 1'b0, 1'b1, 4'h8, imx(4'h7));
    samp(4'hB, 1'b0, 1'b0, 1'b1, 4'h8, imx(4'h7));
    samp(4'hC, 1'b1, 1'b1, 1'b1, 4'hC, imx(4'hB));
    // disable mid-window, then a fresh window
    samp(4'h1, 1'b0, 1'b0, 1'b1, 4'hC, imx(4'hB));
    samp(4'h2, 1'b0, 1'b0, 1'b1, 4'hC, imx(4'hB));
    for (int i = 0; i < 3; i++) add(1'b0, 1'b1, 4'h5, 1'b0, 1'b0, 1'b0, 4'hC, imx(4'hB));
    samp(4'hA, 1'b0, 1'b0, 1'b0, 4'hC, imx(4'hB));
    samp(4'hB, 1'b0, 1'b0, 1'b0, 4'hC, imx(4'hB));
    samp(4'hC, 1'b0, 1'b0, 1'b0, 4'hC, imx(4'hB));
    samp(4'hD, 1'b1, 1'b1, 1'b1, 4'hD, imx(4'hC));

    // reset with enable and random strobes
    for (int i = 0; i < 3; i++) begin
      step(1'b0, 1'b1, 1'($urandom_range(0, 1)), 4'($urandom));
      chk($sformatf("rst%0d.outs", i), {locked_o, strobe_o, framed_o, sig_re_o, sig_im_o}, 32'd0);
    end
    step(1'b1, 1'b0, 1'b0, 4'h0);
    chk("rst_idle.outs", {locked_o, strobe_o, framed_o, sig_re_o, sig_im_o}, 32'd0);

    for (int i = 0; i < tbl.size(); i++) begin
      step(1'b1, tbl[i].en, tbl[i].stb, tbl[i].sig);
      chk($sformatf("tbl%0d.strobe", i), strobe_o, tbl[i].e_stb);
      chk($sformatf("tbl%0d.framed", i), framed_o, tbl[i].e_frm);
      chk($sformatf("tbl%0d.locked", i), locked_o, tbl[i].e_lock);
      chk($sformatf("tbl%0d.re", i), sig_re_o, tbl[i].e_re);
      chk($sformatf("tbl%0d.im", i), sig_im_o, tbl[i].e_im);
    end

    // full-rate strobes for 16 cycles
    for (int i = 0; i < 16; i++) begin
      step(1'b1, 1'b1, 1'b1, 4'(i));
      if (strobe_o) begin
        pulses.push_back(i);
        frms.push_back(framed_o);
      end
    end
    chk("full.count", pulses.size(), 4);
    for (int k = 0; k < pulses.size(); k++) begin
      chk($sformatf("full.pos%0d", k), pulses[k], 3 + 4 * k);
      chk($sformatf("full.frm%0d", k), frms[k], (k % 2 == 1));
    end
    chk("full.re", sig_re_o, 4'hF);
    chk("full.im", sig_im_o, imx(4'hE));

    // enable drop coinciding with the final strobe of a window
    step(1'b1, 1'b1, 1'b1, 4'h1);
    step(1'b1, 1'b1, 1'b1, 4'h2);
    step(1'b1, 1'b1, 1'b1, 4'h3);
    step(1'b1, 1'b0, 1'b1, 4'h4);
    chk("drop.strobe", strobe_o, 1'b0);
    chk("drop.locked", locked_o, 1'b0);
    chk("drop.re", sig_re_o, 4'hF);
    chk("drop.im", sig_im_o, imx(4'hE));
    for (int i = 0; i < 4; i++) begin
      step(1'b1, 1'b1, 1'b1, 4'(5 + i));
      chk($sformatf("reen%0d.strobe", i), strobe_o, (i == 3));
    end
    chk("reen.framed", framed_o, 1'b1);
    chk("reen.re", sig_re_o, 4'h8);
    chk("reen.im", sig_im_o, imx(4'h7));

    // reset mid-window restarts the phase
    step(1'b1, 1'b1, 1'b1, 4'h9);
    step(1'b1, 1'b1, 1'b1, 4'hA);
    step(1'b0, 1'b1, 1'b1, 4'hB);
    chk("mrst.outs", {locked_o, strobe_o, framed_o, sig_re_o, sig_im_o}, 32'd0);
    for (int i = 0; i < 4; i++) begin
      step(1'b1, 1'b1, 1'b1, 4'(2 + i));
      chk($sformatf("mrst%0d.strobe", i), strobe_o, (i == 3));
    end
    chk("mrst.framed", framed_o, 1'b1);
    chk("mrst.re", sig_re_o, 4'h5);
    chk("mrst.im", sig_im_o, imx(4'h4));

    // randomized traffic against the reference model
    for (int i = 0; i < 800; i++) begin
      r = ($urandom_range(0, 49) != 0);
      e = ($urandom_range(0, 9) != 0);
      s = 1'($urandom_range(0, 1));
      d = 4'($urandom);
      step(r, e, s, d);
      chk($sformatf("rnd%0d.strobe", i), strobe_o, m_stb);
      chk($sformatf("rnd%0d.framed", i), framed_o, m_frm);
      chk($sformatf("rnd%0d.locked", i), locked_o, m_lock);
      chk($sformatf("rnd%0d.re", i), sig_re_o, m_re);
      chk($sformatf("rnd%0d.im", i), sig_im_o, m_im);
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
